// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory port between instruction fetch
// and the MEM-stage load/store unit. Data requests have fixed priority.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (bus timeout with d_err pulse).
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_insn,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              stall,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_be,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_drop;
   logic                r_if_ack;
   logic [DATA_W-1:0]   r_if_insn;
   logic                r_d_ack;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                r_m_req;
   logic                r_m_we;
   logic [ADDR_W-1:0]   r_m_addr;
   logic [DATA_W-1:0]   r_m_wdata;
   logic [3:0]          r_m_be;
   logic                w_if_drop;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [DATA_W-1:0] NOP = '0;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_d_err;
`endif

   // A fetch result is discarded if flush was seen earlier in this access or
   // arrives together with the completion.
   assign w_if_drop = r_drop | flush;

   // Arbitration FSM with registered memory handshake and result returns.
   // The ack-pulse guards stop a requester that still holds its request in
   // its ack cycle from being granted a second, duplicate access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_drop    <= 1'b0;
         r_if_ack  <= 1'b0;
         r_if_insn <= '0;
         r_d_ack   <= 1'b0;
         r_d_rdata <= '0;
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_be    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         r_cnt     <= '0;
         r_d_err   <= 1'b0;
`endif
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         r_d_err  <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               r_drop <= 1'b0;
               if (d_req && !r_d_ack) begin
                  r_m_req   <= 1'b1;
                  r_m_we    <= d_we;
                  r_m_addr  <= d_addr;
                  r_m_wdata <= d_wdata;
                  r_m_be    <= d_be;
                  r_state   <= D_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                  r_cnt     <= '0;
`endif
               end else if (if_req && !flush && !r_if_ack) begin
                  r_m_req   <= 1'b1;
                  r_m_we    <= 1'b0;
                  r_m_addr  <= if_addr;
                  r_m_be    <= 4'hF;
                  r_state   <= IF_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                  r_cnt     <= '0;
`endif
               end
            end
            IF_BUSY: begin
               if (flush) r_drop <= 1'b1;
               if (m_ack) begin
                  r_m_req <= 1'b0;
                  r_state <= IDLE;
                  r_drop  <= 1'b0;
                  if (!w_if_drop) begin
                     r_if_ack  <= 1'b1;
                     r_if_insn <= m_rdata;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_m_req <= 1'b0;
                  r_state <= IDLE;
                  r_drop  <= 1'b0;
                  if (!w_if_drop) begin
                     r_if_ack  <= 1'b1;
                     r_d_err   <= 1'b1;
                     r_if_insn <= NOP;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            D_BUSY: begin
               if (m_ack) begin
                  r_m_req <= 1'b0;
                  r_state <= IDLE;
                  r_d_ack <= 1'b1;
                  if (!r_m_we) r_d_rdata <= m_rdata;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_m_req <= 1'b0;
                  r_state <= IDLE;
                  r_d_ack <= 1'b1;
                  r_d_err <= 1'b1;
                  if (!r_m_we) r_d_rdata <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_ack  = r_if_ack;
   assign if_insn = r_if_insn;
   assign d_ack   = r_d_ack;
   assign d_rdata = r_d_rdata;
   assign m_req   = r_m_req;
   assign m_we    = r_m_we;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign m_be    = r_m_be;

`ifdef MEM_ARB_TIMEOUT_EN
   assign d_err = r_d_err;
`else
   assign d_err = 1'b0;
`endif

   // Stall drops in the ack cycle so the stage register captures the result.
   assign stall = (if_req & ~r_if_ack) | (d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change and outputs
// are checked at the falling clock edge; the DUT updates on the rising edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        flush;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        if_ack;
   logic [31:0] if_insn;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        stall;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_ack;
   logic [31:0] m_rdata;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .if_req  (if_req),
      .if_addr (if_addr),
      .flush   (flush),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_be    (d_be),
      .if_ack  (if_ack),
      .if_insn (if_insn),
      .d_ack   (d_ack),
      .d_rdata (d_rdata),
      .d_err   (d_err),
      .stall   (stall),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_be    (m_be),
      .m_ack   (m_ack),
      .m_rdata (m_rdata)
   );

   always #5 clk = ~clk;

   task automatic nxt;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      m_ack = 1'b0; m_rdata = '0;
      nxt; nxt;
      n_checks++;
      if ({if_ack, d_ack, d_err, stall, m_req, m_we} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {if_ack, d_ack, d_err, stall, m_req, m_we});
      end
      n_checks++;
      if ({if_insn, d_rdata, m_addr, m_wdata, m_be} !== 132'b0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h/%h expected all zero", if_insn, d_rdata, m_addr, m_wdata, m_be);
      end
      rst = 1'b0;
      nxt;
   endtask

   task automatic test_single_fetch;
      // cycle 0
      if_req = 1'b1; if_addr = 32'h100; #1;
      n_checks++;
      if ({stall, m_req} !== 2'b10) begin
         n_fail++; $display("FAIL fetch_c0: stall,m_req got %b expected 10", {stall, m_req});
      end
      nxt; // cycle 1
      n_checks++;
      if ({m_req, m_we, m_be, m_addr, stall} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b1}) begin
         n_fail++; $display("FAIL fetch_c1: m_req=%b m_we=%b m_be=%h m_addr=%h stall=%b expected 1 0 f 00000100 1", m_req, m_we, m_be, m_addr, stall);
      end
      nxt; // cycle 2
      n_checks++;
      if ({m_req, stall, if_ack} !== 3'b110) begin
         n_fail++; $display("FAIL fetch_c2: m_req,stall,if_ack got %b expected 110", {m_req, stall, if_ack});
      end
      m_ack = 1'b1; m_rdata = 32'h2402_0005;
      nxt; // cycle 3
      m_ack = 1'b0; m_rdata = '0;
      n_checks++;
      if ({if_ack, stall, m_req} !== 3'b100 || if_insn !== 32'h2402_0005) begin
         n_fail++; $display("FAIL fetch_c3: if_ack,stall,m_req=%b if_insn=%h expected 100 24020005", {if_ack, stall, m_req}, if_insn);
      end
      nxt; // cycle 4: request held through ack cycle must not be re-granted
      if_req = 1'b0; #1;
      n_checks++;
      if ({if_ack, m_req, stall} !== 3'b000) begin
         n_fail++; $display("FAIL fetch_c4: if_ack,m_req,stall got %b expected 000", {if_ack, m_req, stall});
      end
   endtask

   task automatic test_priority;
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
      nxt; // cycle 1: data wins
      n_checks++;
      if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h200}) begin
         n_fail++; $display("FAIL prio_grant: m_req=%b m_we=%b m_addr=%h expected 1 0 00000200", m_req, m_we, m_addr);
      end
      m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
      nxt; // cycle 2: d_ack, idle gap
      m_ack = 1'b0; m_rdata = '0;
      n_checks++;
      if ({d_ack, if_ack, m_req, stall} !== 4'b1001 || d_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL prio_dack: d_ack,if_ack,m_req,stall=%b d_rdata=%h expected 1001 deadbeef", {d_ack, if_ack, m_req, stall}, d_rdata);
      end
      nxt; // cycle 3: fetch granted
      d_req = 1'b0;
      n_checks++;
      if ({m_req, m_addr, d_ack} !== {1'b1, 32'h300, 1'b0}) begin
         n_fail++; $display("FAIL prio_fetch_grant: m_req=%b m_addr=%h d_ack=%b expected 1 00000300 0", m_req, m_addr, d_ack);
      end
      m_ack = 1'b1; m_rdata = 32'h1111_1111;
      nxt; // cycle 4
      m_ack = 1'b0; m_rdata = '0;
      n_checks++;
      if ({if_ack, stall, m_req} !== 3'b100 || if_insn !== 32'h1111_1111) begin
         n_fail++; $display("FAIL prio_ifack: if_ack,stall,m_req=%b if_insn=%h expected 100 11111111", {if_ack, stall, m_req}, if_insn);
      end
      nxt;
      if_req = 1'b0;
      nxt;
   endtask

   task automatic test_store;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h1234_5678; d_be = 4'b0011;
      nxt; // cycle 1
      n_checks++;
      if ({m_req, m_we, m_addr, m_wdata, m_be} !== {1'b1, 1'b1, 32'h204, 32'h1234_5678, 4'b0011}) begin
         n_fail++; $display("FAIL store_grant: m_req=%b m_we=%b m_addr=%h m_wdata=%h m_be=%b expected 1 1 00000204 12345678 0011", m_req, m_we, m_addr, m_wdata, m_be);
      end
      d_addr = 32'hFFFF_FFF0; d_wdata = 32'h0; d_be = 4'hF; // must not disturb the held request
      nxt; // cycle 2: still held
      n_checks++;
      if ({m_req, m_addr, m_wdata, m_be} !== {1'b1, 32'h204, 32'h1234_5678, 4'b0011}) begin
         n_fail++; $display("FAIL store_hold: m_req=%b m_addr=%h m_wdata=%h m_be=%b expected 1 00000204 12345678 0011", m_req, m_addr, m_wdata, m_be);
      end
      m_ack = 1'b1; m_rdata = 32'hAAAA_AAAA;
      nxt; // cycle 3
      m_ack = 1'b0; m_rdata = '0;
      n_checks++;
      if ({d_ack, d_err, m_req, stall} !== 4'b1000 || d_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL store_ack: d_ack,d_err,m_req,stall=%b d_rdata=%h expected 1000 deadbeef", {d_ack, d_err, m_req, stall}, d_rdata);
      end
      nxt; // cycle 4: no duplicate store
      d_req = 1'b0; d_we = 1'b0;
      n_checks++;
      if ({m_req, d_ack} !== 2'b00) begin
         n_fail++; $display("FAIL store_nodup: m_req,d_ack got %b expected 00", {m_req, d_ack});
      end
   endtask

   task automatic test_flush;
      // flush in IDLE blocks the grant
      if_req = 1'b1; if_addr = 32'h400; flush = 1'b1;
      nxt;
      n_checks++;
      if (m_req !== 1'b0) begin
         n_fail++; $display("FAIL flush_idle: m_req got %b expected 0", m_req);
      end
      flush = 1'b0;
      nxt; // granted now
      n_checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h400}) begin
         n_fail++; $display("FAIL flush_grant: m_req=%b m_addr=%h expected 1 00000400", m_req, m_addr);
      end
      flush = 1'b1;
      nxt;
      flush = 1'b0; if_addr = 32'h500;
      m_ack = 1'b1; m_rdata = 32'h9999_9999;
      nxt;
      m_ack = 1'b0; m_rdata = '0;
      n_checks++;
      if ({if_ack, m_req, stall} !== 3'b001 || if_insn !== 32'h1111_1111) begin
         n_fail++; $display("FAIL flush_drop: if_ack,m_req,stall=%b if_insn=%h expected 001 11111111", {if_ack, m_req, stall}, if_insn);
      end
      nxt; // new fetch proceeds
      n_checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h500}) begin
         n_fail++; $display("FAIL flush_refetch: m_req=%b m_addr=%h expected 1 00000500", m_req, m_addr);
      end
      m_ack = 1'b1; m_rdata = 32'h2222_2222;
      nxt;
      m_ack = 1'b0; m_rdata = '0;
      n_checks++;
      if ({if_ack, stall} !== 2'b10 || if_insn !== 32'h2222_2222) begin
         n_fail++; $display("FAIL flush_refetch_ack: if_ack,stall=%b if_insn=%h expected 10 22222222", {if_ack, stall}, if_insn);
      end
      nxt;
      if_req = 1'b0;
      nxt;
   endtask

   task automatic test_async_reset;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h208; d_be = 4'hF;
      nxt;
      n_checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h208}) begin
         n_fail++; $display("FAIL arst_pre: m_req=%b m_addr=%h expected 1 00000208", m_req, m_addr);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({m_req, m_addr, m_be, d_rdata, if_insn, d_ack, if_ack} !== {1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL arst_now: m_req=%b m_addr=%h m_be=%h d_rdata=%h if_insn=%h expected 0 0 0 0 0", m_req, m_addr, m_be, d_rdata, if_insn);
      end
      d_req = 1'b0;
      #1 rst = 1'b0;
      nxt;
      n_checks++;
      if ({m_req, stall, d_ack} !== 3'b000) begin
         n_fail++; $display("FAIL arst_idle: m_req,stall,d_ack got %b expected 000", {m_req, stall, d_ack});
      end
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout;
      if_req = 1'b1; if_addr = 32'h600;
      for (int i = 1; i <= 4; i++) begin
         nxt;
         n_checks++;
         if ({m_req, if_ack, d_err} !== 3'b100) begin
            n_fail++; $display("FAIL timeout_wait%0d: m_req,if_ack,d_err got %b expected 100", i, {m_req, if_ack, d_err});
         end
      end
      nxt;
      n_checks++;
      if ({m_req, if_ack, d_err} !== 3'b011 || if_insn !== 32'h0) begin
         n_fail++; $display("FAIL timeout_err: m_req,if_ack,d_err=%b if_insn=%h expected 011 00000000", {m_req, if_ack, d_err}, if_insn);
      end
      nxt;
      if_req = 1'b0;
      nxt;
   endtask
`endif

   initial begin
      test_reset;
      test_single_fetch;
      test_priority;
      test_store;
      test_flush;
      test_async_reset;
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
